// File: rtl/traffic_conflict_monitor.sv
// Independent safety monitor for a two-direction traffic cabinet.
// Debounces the EW and NS lamp drives, checks legal codes, phase order,
// minimum yellow dwell and cross-direction conflicts, then latches the
// first fault and drives a flashing-red override until cleared.
module traffic_conflict_monitor #(
  parameter int DEBOUNCE   = 2,
  parameter int MIN_YELLOW = 3,
  parameter int FLASH_HALF = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] ew_lamps,
  input  logic [3:0] ns_lamps,
  input  logic       emergency,
  input  logic       fault_clear,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic       fault_dir,
  output logic       flash
);

  localparam logic [3:0] RED    = 4'b0001;
  localparam logic [3:0] YELLOW = 4'b0010;
  localparam logic [3:0] GREEN  = 4'b0100;
  localparam logic [3:0] ARROW  = 4'b1001;

  typedef enum logic {MONITOR, FAULT} state_t;

  state_t     state;
  logic [7:0] flash_cnt;

  logic [3:0] ew_cand, ns_cand, ew_stable, ns_stable;
  logic [2:0] ew_cnt, ns_cnt, ew_cnt_nx, ns_cnt_nx;
  logic [4:0] ew_dwell, ns_dwell;
  logic       ew_pre, ns_pre;
  logic       ew_upd, ns_upd;
  logic [3:0] ew_stable_nx, ns_stable_nx;
  logic       ew_bad_code, ns_bad_code, ew_short, ns_short, ew_seq, ns_seq;
  logic       conflict, clear_evt, viol;
  logic [2:0] viol_code;
  logic       viol_dir;

  function automatic logic is_legal(input logic [3:0] c);
    return (c == RED) || (c == YELLOW) || (c == GREEN) || (c == ARROW);
  endfunction

  function automatic logic is_perm(input logic [3:0] c);
    return |c[3:1];
  endfunction

  function automatic logic allowed(input logic [3:0] from, input logic [3:0] to);
    case (from)
      RED:     return (to == GREEN) || (to == ARROW);
      ARROW:   return to == GREEN;
      GREEN:   return to == YELLOW;
      YELLOW:  return to == RED;
      default: return 1'b0;
    endcase
  endfunction

  // A differing sample restarts the count; the candidate always becomes the sample.
  function automatic logic [2:0] cnt_next(input logic [3:0] s, input logic [3:0] cand,
                                          input logic [2:0] cnt);
    if (s != cand) return 3'd1;
    else if (cnt == 3'd7) return cnt;
    else return cnt + 3'd1;
  endfunction

  // Debounce decisions and violation flags for both directions.
  // Update events use the post-edge candidate so a fault lands on the same edge.
  always_comb begin
    ew_cnt_nx    = cnt_next(ew_lamps, ew_cand, ew_cnt);
    ns_cnt_nx    = cnt_next(ns_lamps, ns_cand, ns_cnt);
    ew_upd       = (ew_cnt_nx >= 3'(DEBOUNCE)) && (ew_lamps != ew_stable);
    ns_upd       = (ns_cnt_nx >= 3'(DEBOUNCE)) && (ns_lamps != ns_stable);
    ew_stable_nx = ew_upd ? ew_lamps : ew_stable;
    ns_stable_nx = ns_upd ? ns_lamps : ns_stable;

    ew_bad_code  = ew_upd && !is_legal(ew_lamps);
    ns_bad_code  = ns_upd && !is_legal(ns_lamps);
    ew_short     = ew_upd && (ew_stable == YELLOW) && (ew_dwell < 5'(MIN_YELLOW)) && !emergency;
    ns_short     = ns_upd && (ns_stable == YELLOW) && (ns_dwell < 5'(MIN_YELLOW)) && !emergency;
    ew_seq       = ew_upd && !ew_pre && !allowed(ew_stable, ew_lamps) &&
                   !((ew_lamps == RED) && emergency);
    ns_seq       = ns_upd && !ns_pre && !allowed(ns_stable, ns_lamps) &&
                   !((ns_lamps == RED) && emergency);
    conflict     = is_perm(ew_stable_nx) && is_perm(ns_stable_nx);

    viol      = 1'b1;
    viol_code = 3'b000;
    viol_dir  = 1'b0;
    if (conflict)         begin viol_code = 3'b001; viol_dir = 1'b0; end
    else if (ew_bad_code) begin viol_code = 3'b010; viol_dir = 1'b0; end
    else if (ns_bad_code) begin viol_code = 3'b010; viol_dir = 1'b1; end
    else if (ew_short)    begin viol_code = 3'b011; viol_dir = 1'b0; end
    else if (ns_short)    begin viol_code = 3'b011; viol_dir = 1'b1; end
    else if (ew_seq)      begin viol_code = 3'b100; viol_dir = 1'b0; end
    else if (ns_seq)      begin viol_code = 3'b100; viol_dir = 1'b1; end
    else                  viol = 1'b0;

    clear_evt = (state == FAULT) && fault_clear && (ew_stable == RED) && (ns_stable == RED);
  end

  // Per-direction debounce, dwell and preemption tracking; runs in every state.
  always_ff @(posedge clk) begin
    if (reset) begin
      ew_cand   <= RED;           ns_cand   <= RED;
      ew_stable <= RED;           ns_stable <= RED;
      ew_cnt    <= 3'(DEBOUNCE);  ns_cnt    <= 3'(DEBOUNCE);
      ew_dwell  <= '0;            ns_dwell  <= '0;
      ew_pre    <= 1'b0;          ns_pre    <= 1'b0;
    end else begin
      ew_cand   <= ew_lamps;      ns_cand   <= ns_lamps;
      ew_cnt    <= ew_cnt_nx;     ns_cnt    <= ns_cnt_nx;
      ew_stable <= ew_stable_nx;  ns_stable <= ns_stable_nx;

      if (ew_upd)               ew_dwell <= 5'd1;
      else if (ew_dwell != '1)  ew_dwell <= ew_dwell + 5'd1;
      if (ns_upd)               ns_dwell <= 5'd1;
      else if (ns_dwell != '1)  ns_dwell <= ns_dwell + 5'd1;

      if (clear_evt || ew_upd)                      ew_pre <= 1'b0;
      else if ((ew_stable == RED) && emergency)     ew_pre <= 1'b1;
      if (clear_evt || ns_upd)                      ns_pre <= 1'b0;
      else if ((ns_stable == RED) && emergency)     ns_pre <= 1'b1;
    end
  end

  // Monitor/fault FSM with registered fault outputs and flash generator.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= MONITOR;
      fault      <= 1'b0;
      fault_code <= '0;
      fault_dir  <= 1'b0;
      flash      <= 1'b0;
      flash_cnt  <= '0;
    end else begin
      case (state)
        MONITOR: begin
          if (viol) begin
            state      <= FAULT;
            fault      <= 1'b1;
            fault_code <= viol_code;
            fault_dir  <= viol_dir;
            flash      <= 1'b1;
            flash_cnt  <= '0;
          end
        end
        FAULT: begin
          if (clear_evt) begin
            state      <= MONITOR;
            fault      <= 1'b0;
            fault_code <= '0;
            fault_dir  <= 1'b0;
            flash      <= 1'b0;
            flash_cnt  <= '0;
          end else if (flash_cnt == 8'(FLASH_HALF - 1)) begin
            flash     <= ~flash;
            flash_cnt <= '0;
          end else begin
            flash_cnt <= flash_cnt + 8'd1;
          end
        end
        default: state <= MONITOR;
      endcase
    end
  end

endmodule
